// File: rtl/arb_mux_pkg.sv
// Shared constants and types for the 4:1 round-robin arbitrating mux.
// Imported by rr_pick_4 and arb_mux_4_1.
package arb_mux_pkg;

    localparam int N_CH  = 4;
    localparam int W_DEF = 4;

    typedef logic [1:0] ch_idx_t;

    function automatic ch_idx_t next_idx(input ch_idx_t i, input int unsigned k);
        return ch_idx_t'(32'(i) + k);
    endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin picker: first requester after `last`, wrapping.
// Pure logic, no state; the caller owns the `last` register.
module rr_pick_4
    import arb_mux_pkg::*;
(
    input  logic [N_CH-1:0] req,
    input  ch_idx_t         last,
    output logic            gnt_valid,
    output ch_idx_t         gnt_idx
);

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = last;
        // Scan farthest to nearest so the closest requester after last wins.
        for (int unsigned k = N_CH; k >= 1; k--) begin
            if (req[next_idx(last, k)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = next_idx(last, k);
            end
        end
    end

endmodule

// File: rtl/arb_mux_4_1.sv
// 4-channel round-robin arbiter with a registered one-word output stage.
// Define ARB_MUX_STATS_EN to add saturating per-channel grant counters.
module arb_mux_4_1
    import arb_mux_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH-1:0][W-1:0] in_data,
    input  logic [N_CH-1:0]        in_valid,
    output logic [N_CH-1:0]        in_ready,
    output logic [W-1:0]           out_data,
    output ch_idx_t                out_sel,
    output logic                   out_valid,
    input  logic                   out_ready
`ifdef ARB_MUX_STATS_EN
    ,
    output logic [N_CH-1:0][7:0]   grant_cnt
`endif
);

    logic    load;
    logic    gnt_valid;
    logic    xfer;
    ch_idx_t gnt_idx;
    ch_idx_t last;
    logic [W-1:0] sel_data;

    assign load = !out_valid || out_ready;

    rr_pick_4 u_pick (
        .req       (in_valid),
        .last      (last),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    // Reset gates the handshake so nothing is accepted during rst_n=0.
    assign xfer     = rst_n && load && gnt_valid;
    assign sel_data = in_data[gnt_idx];

    always_comb begin
        in_ready = '0;
        if (xfer) in_ready[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            last      <= ch_idx_t'(N_CH - 1);
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= gnt_idx;
            last      <= gnt_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ARB_MUX_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_cnt <= '0;
        end else if (xfer && grant_cnt[gnt_idx] != 8'hFF) begin
            grant_cnt[gnt_idx] <= grant_cnt[gnt_idx] + 8'd1;
        end
    end
`endif

endmodule
